// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: game control FSM. It sequences the datapath through
// each round (load pattern, wait for a press, verify it, blink on a hit,
// advance the step) and reports win, loss or timeout to the top level.
// Optional feature macro: JOGO_TIMEOUT_EN. When it is defined, the timeout
// input ends the game from espera_jogada. When it is undefined, the timeout
// input is ignored and perdeu_timeout is tied to 0.
module unidade_controle_jogo #(
  parameter int unsigned BLINKS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       acertouJogada,
  input  logic       jogadaAtualEQUALSacertoAnterior,
  input  logic       acertoAnteriorEQUALSzero,
  input  logic       tem_jogada,
  input  logic       fimS,
  input  logic       fimLedsOn,
  input  logic       fimLedsOff,
  input  logic       fimPiscaLeds,
  input  logic       timeout,
  output logic       zeraT,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraA,
  output logic       registraA,
  output logic       contaA,
  output logic       contaPiscadas,
  output logic       contaLedsOn,
  output logic       contaLedsOff,
  output logic       zeraL,
  output logic       registraL,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       perdeu_timeout,
  output logic [3:0] db_estado
);

  // The blink count lives in the datapath counter; zero blinks is meaningless.
  if (BLINKS == 0) begin : gBlinksInvalid
    $error("BLINKS must be nonzero");
  end

  typedef enum logic [3:0] {
    inicial       = 4'h0,
    preparacao    = 4'h1,
    carrega_led   = 4'h2,
    espera_jogada = 4'h3,
    registra      = 4'h4,
    compara       = 4'h5,
    acerto        = 4'h6,
    pisca_on      = 4'h7,
    pisca_off     = 4'h8,
    proxima       = 4'h9,
    fim_ganhou    = 4'hA,
    fim_errou     = 4'hB,
    fim_timeout   = 4'hC
  } estado_t;

  estado_t estadoAtual;
  estado_t proximoEstado;
  logic    erroJogada;

  // A wrong press, or a repeat of the last hit when a hit is stored.
  assign erroJogada = !acertouJogada ||
                      (jogadaAtualEQUALSacertoAnterior && !acertoAnteriorEQUALSzero);

  assign db_estado = estadoAtual;

  // State register. An asynchronous reset aborts to inicial from any state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estadoAtual <= inicial;
    else        estadoAtual <= proximoEstado;
  end

  // Next-state logic and strobes. Moore outputs, except that contaPiscadas and contaS are Mealy.
  always_comb begin
    proximoEstado  = estadoAtual;
    zeraT          = 1'b0;
    zeraS          = 1'b0;
    contaS         = 1'b0;
    zeraR          = 1'b0;
    registraR      = 1'b0;
    zeraA          = 1'b0;
    registraA      = 1'b0;
    contaA         = 1'b0;
    contaPiscadas  = 1'b0;
    contaLedsOn    = 1'b0;
    contaLedsOff   = 1'b0;
    zeraL          = 1'b0;
    registraL      = 1'b0;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    perdeu_timeout = 1'b0;
    case (estadoAtual)
      inicial: begin
        if (iniciar) proximoEstado = preparacao;
      end
      preparacao: begin
        zeraS = 1'b1;
        zeraR = 1'b1;
        zeraA = 1'b1;
        zeraL = 1'b1;
        zeraT = 1'b1;
        proximoEstado = carrega_led;
      end
      carrega_led: begin
        registraL = 1'b1;
        zeraT     = 1'b1;
        proximoEstado = espera_jogada;
      end
      espera_jogada: begin
`ifdef JOGO_TIMEOUT_EN
        if (timeout)         proximoEstado = fim_timeout;
        else if (tem_jogada) proximoEstado = registra;
`else
        // timeout is read here but has no effect: the FSM waits either way.
        if (tem_jogada)      proximoEstado = registra;
        else if (timeout)    proximoEstado = espera_jogada;
`endif
      end
      registra: begin
        registraR = 1'b1;
        proximoEstado = compara;
      end
      compara: begin
        proximoEstado = erroJogada ? fim_errou : acerto;
      end
      acerto: begin
        contaA    = 1'b1;
        registraA = 1'b1;
        proximoEstado = pisca_on;
      end
      pisca_on: begin
        registraL   = 1'b1;
        contaLedsOn = 1'b1;
        if (fimLedsOn) proximoEstado = pisca_off;
      end
      pisca_off: begin
        zeraL         = 1'b1;
        contaLedsOff  = 1'b1;
        contaPiscadas = fimLedsOff;
        if (fimLedsOff) proximoEstado = fimPiscaLeds ? proxima : pisca_on;
      end
      proxima: begin
        contaS = !fimS;
        proximoEstado = fimS ? fim_ganhou : carrega_led;
      end
      fim_ganhou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
        if (iniciar) proximoEstado = preparacao;
      end
      fim_errou: begin
        pronto = 1'b1;
        perdeu = 1'b1;
        if (iniciar) proximoEstado = preparacao;
      end
      fim_timeout: begin
        pronto = 1'b1;
`ifdef JOGO_TIMEOUT_EN
        perdeu_timeout = 1'b1;
`endif
        if (iniciar) proximoEstado = preparacao;
      end
      default: proximoEstado = inicial;
    endcase
  end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore/Mealy control FSM sitting directly upstream of the game datapath; drives every datapath control strobe and consumes its status flags.
- Per round:
  - loads the current LED pattern and waits for a button press;
  - checks the press against the expected pattern and the "no repeat of previous hit" rule;
  - blinks the LEDs 3 times on a hit, then advances the 16-step sequence.
- Ends in win, loss or timeout and reports the result to the top level.

Parameters:
- BLINKS, 3, number of LED blinks after a hit. Must match the datapath blink counter modulus; informational only.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces state inicial immediately.
- iniciar  in  1  start/restart request, level sampled.
- acertouJogada  in  1  registered press overlaps expected pattern.
- jogadaAtualEQUALSacertoAnterior  in  1  press equals previous hit.
- acertoAnteriorEQUALSzero  in  1  no previous hit stored.
- tem_jogada  in  1  one-cycle press pulse.
- fimS  in  1  sequence counter at last step (15).
- fimLedsOn  in  1  LED-on timer done.
- fimLedsOff  in  1  LED-off timer done.
- fimPiscaLeds  in  1  blink counter at last blink.
- timeout  in  1  sticky timeout flag.
- zeraT, zeraS, contaS, zeraR, registraR, zeraA, registraA, contaA  out  1 each  datapath strobes.
- contaPiscadas, contaLedsOn, contaLedsOff, zeraL, registraL  out  1 each  datapath strobes.
- pronto  out  1  game over (any outcome).
- ganhou  out  1  win.
- perdeu  out  1  wrong press.
- perdeu_timeout  out  1  loss by timeout.
- db_estado  out  4  current state code.

Behaviour:
- State codes:
  - inicial=0, preparacao=1, carrega_led=2, espera_jogada=3, registra=4, compara=5, acerto=6, pisca_on=7, pisca_off=8, proxima=9;
  - fim_ganhou=A, fim_errou=B, fim_timeout=C;
  - unused codes go to inicial on the next clock.
- On reset low: state=inicial and all outputs 0 except db_estado=0.
- Transitions and outputs (Moore unless stated; an output not listed for a state is 0):
  - inicial: iniciar → preparacao.
  - preparacao: zeraS, zeraR, zeraA, zeraL, zeraT = 1. Unconditional → carrega_led.
  - carrega_led: registraL=1, zeraT=1 (restarts the timer each round). → espera_jogada.
  - espera_jogada: timeout → fim_timeout (timeout has priority over a same-cycle tem_jogada); else tem_jogada → registra; else stay.
  - registra: registraR=1. → compara. The compare inputs are valid from compara onward.
  - compara:
    - error = !acertouJogada OR (jogadaAtualEQUALSacertoAnterior AND !acertoAnteriorEQUALSzero);
    - error → fim_errou; else → acerto.
  - acerto: contaA=1, registraA=1. → pisca_on.
  - pisca_on: registraL=1, contaLedsOn=1. fimLedsOn → pisca_off.
  - pisca_off: zeraL=1, contaLedsOff=1. contaPiscadas is Mealy: 1 only in the cycle with fimLedsOff=1.
    - fimLedsOff AND fimPiscaLeds → proxima;
    - fimLedsOff AND !fimPiscaLeds → pisca_on;
    - the blink counter wraps to 0 on the same edge, so no clear is needed between rounds.
  - proxima: contaS is Mealy: contaS = !fimS. fimS → fim_ganhou; else → carrega_led.
  - fim_ganhou / fim_errou / fim_timeout: pronto=1 plus ganhou, perdeu or perdeu_timeout respectively. iniciar → preparacao; else hold.
- A press during blinking is ignored (tem_jogada is a pulse and is not latched).
- Reset low in any state aborts to inicial within the same cycle.
- iniciar held high through an end state restarts exactly once per entry to preparacao.
- Latency, press to verdict: tem_jogada at cycle n → compara at n+2 → end or acerto state at n+3.

Optional Feature:
- Macro: JOGO_TIMEOUT_EN.
- Defined: behaviour as above.
- Undefined:
  - the timeout input is ignored and espera_jogada waits indefinitely;
  - fim_timeout is unreachable and perdeu_timeout is tied to 0;
  - zeraT is still driven as specified.

Test Plan:
1. reset low mid-pisca_on → db_estado=0 immediately, all strobes 0; after release with iniciar=1 → preparacao (1) on the next edge with all five zera strobes = 1.
2. Correct, non-repeating press at step 0 (acertouJogada=1, equality=0) → contaA and registraA each 1 for one cycle; exactly 3 pisca_on/pisca_off pairs; 3 contaPiscadas pulses; one contaS pulse; back to carrega_led.
3. Press with acertouJogada=0 → fim_errou: pronto=1, perdeu=1, db_estado=B. With iniciar=1 → preparacao.
4. Repeat of the previous hit (equality=1, acertoAnteriorEQUALSzero=0, acertouJogada=1) → fim_errou. The same inputs with acertoAnteriorEQUALSzero=1 → acerto.
5. All 16 steps correct, fimS=1 at proxima → no contaS pulse, fim_ganhou, ganhou=1.
6. timeout=1 together with tem_jogada in espera_jogada:
   - with JOGO_TIMEOUT_EN → fim_timeout, perdeu_timeout=1;
   - without the macro → registra, and timeout alone keeps the FSM in state 3.
